adaptive_threshold_writer: RTL and testbench

ADAPTIVE_THRESHOLD_WRITER -- requirements
Module: adaptive_threshold_writer

---
 rtl/adaptive_threshold_writer_pkg.sv | 26 ++
 rtl/adaptive_threshold_writer_noise_accumulator.sv | 46 ++++
 rtl/adaptive_threshold_writer.sv | 133 +++++++++++++
 tb/tb_adaptive_threshold_writer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/adaptive_threshold_writer_pkg.sv
// Shared types and constants for the adaptive threshold writer: FSM encoding,
// default settings-bus addresses and the saturating threshold scaler.
package adaptive_threshold_writer_pkg;

   localparam int TH_ADDR_DEF = 1;
   localparam int WS_ADDR_DEF = 3;
   localparam int ACC_W       = 42;

   typedef enum logic [2:0] {
      INIT_WS,
      IDLE,
      ACCUM,
      SCALE,
      WRITE
   } state_e;

   // Q8.8 multiply of the block mean, clipped to the 32-bit register range.
   function automatic logic [31:0] scale_sat(input logic [31:0] mean,
                                             input logic [15:0] scale);
      logic [47:0] prod;
      prod = ({16'b0, mean} * {32'b0, scale}) >> 8;
      if (prod[47:32] != '0) return 32'hFFFF_FFFF;
      return prod[31:0];
   endfunction

endpackage

// File: rtl/adaptive_threshold_writer_noise_accumulator.sv
// Block accumulator for FFT magnitudes: running sum plus sample counter whose
// terminal count flags the sample that completes a 2^LOG2_BLOCK block.
module noise_accumulator
   import adaptive_threshold_writer_pkg::*;
#(
   parameter int LOG2_BLOCK = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sclr,
   input  logic             en,
   input  logic [31:0]      data,
   output logic [ACC_W-1:0] acc,
   output logic             tc
);

   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [LOG2_BLOCK-1:0] cnt_q, cnt_d;

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (sclr) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (en) begin
         acc_d = acc_q + ACC_W'(data);
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign acc = acc_q;
   // High in the cycle the last sample of the block is being accepted.
   assign tc  = en && !sclr && (cnt_q == '1);

endmodule

// File: rtl/adaptive_threshold_writer.sv
// Noise-floor driven detection threshold: averages FFT magnitudes per block,
// scales the mean and writes it onto a settings bus shared with a host.
module adaptive_threshold_writer
   import adaptive_threshold_writer_pkg::*;
#(
   parameter int TH_ADDR    = TH_ADDR_DEF,
   parameter int WS_ADDR    = WS_ADDR_DEF,
   parameter int LOG2_BLOCK = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] xk_d_fct,
   input  logic        dv_d_fct,
   input  logic [15:0] scale,
   input  logic [9:0]  window_size_cfg,
   input  logic        ws_load,
   input  logic        host_stb,
   input  logic [7:0]  host_addr,
   input  logic [31:0] host_data,
   output logic        set_stb,
   output logic [7:0]  set_addr,
   output logic [31:0] set_data,
   output logic [31:0] th_current,
   output logic [15:0] upd_cnt
);

   state_e            state_q, state_d;
   logic              set_stb_q, set_stb_d;
   logic [7:0]        set_addr_q, set_addr_d;
   logic [31:0]       set_data_q, set_data_d;
   logic [31:0]       th_q, th_d;
   logic [15:0]       upd_q, upd_d;
   logic              thr_pend_q, thr_pend_d;
   logic              ws_pend_q, ws_pend_d;

   logic              acc_sclr, acc_en, acc_tc, thr_due;
   logic [ACC_W-1:0]  acc, acc_sh;
   logic [31:0]       th_calc;
   logic              unused_acc_hi;

   noise_accumulator #(.LOG2_BLOCK(LOG2_BLOCK)) u_acc (
      .clock (clock),
      .reset (reset),
      .sclr  (acc_sclr),
      .en    (acc_en),
      .data  (xk_d_fct),
      .acc   (acc),
      .tc    (acc_tc)
   );

   assign acc_sh        = acc >> LOG2_BLOCK;
   assign unused_acc_hi = ^acc_sh[ACC_W-1:32];
   assign th_calc       = scale_sat(acc_sh[31:0], scale);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= INIT_WS;
         set_stb_q  <= 1'b0;
         set_addr_q <= '0;
         set_data_q <= '0;
         th_q       <= '0;
         upd_q      <= '0;
         thr_pend_q <= 1'b0;
         ws_pend_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         set_stb_q  <= set_stb_d;
         set_addr_q <= set_addr_d;
         set_data_q <= set_data_d;
         th_q       <= th_d;
         upd_q      <= upd_d;
         thr_pend_q <= thr_pend_d;
         ws_pend_q  <= ws_pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT_WS: if (!host_stb) state_d = IDLE;
         IDLE:    if (enable) state_d = ACCUM;
         ACCUM:   if (!enable) state_d = IDLE;
                  else if (acc_tc) state_d = SCALE;
         SCALE:   state_d = WRITE;
         WRITE:   if (!(thr_pend_q && host_stb)) state_d = enable ? ACCUM : IDLE;
         default: state_d = INIT_WS;
      endcase
   end

   // The threshold is loaded into the bus register straight from SCALE so it
   // shows two cycles after the last sample; WRITE only retries a lost slot.
   always_comb begin
      acc_sclr   = (state_q == IDLE) || (state_q == WRITE);
      acc_en     = (state_q == ACCUM) && enable && dv_d_fct;
      thr_due    = (state_q == SCALE) || ((state_q == WRITE) && thr_pend_q);
      set_stb_d  = 1'b0;
      set_addr_d = set_addr_q;
      set_data_d = set_data_q;
      th_d       = (state_q == SCALE) ? th_calc : th_q;
      upd_d      = upd_q;
      thr_pend_d = thr_pend_q;
      ws_pend_d  = ws_pend_q | ws_load;
      if (host_stb) begin
         set_stb_d  = 1'b1;
         set_addr_d = host_addr;
         set_data_d = host_data;
         if (state_q == SCALE) thr_pend_d = 1'b1;
      end else if (thr_due) begin
         set_stb_d  = 1'b1;
         set_addr_d = 8'(TH_ADDR);
         set_data_d = th_d;
         upd_d      = upd_q + 1'b1;
         thr_pend_d = 1'b0;
      end else if (state_q == INIT_WS) begin
         set_stb_d  = 1'b1;
         set_addr_d = 8'(WS_ADDR);
         set_data_d = {22'b0, window_size_cfg};
      end else if (ws_pend_q) begin
         set_stb_d  = 1'b1;
         set_addr_d = 8'(WS_ADDR);
         set_data_d = {22'b0, window_size_cfg};
         ws_pend_d  = ws_load;
      end
   end

   assign set_stb    = set_stb_q;
   assign set_addr   = set_addr_q;
   assign set_data   = set_data_q;
   assign th_current = th_q;
   assign upd_cnt    = upd_q;

endmodule

// File: tb/tb_adaptive_threshold_writer.sv
// Directed bench for adaptive_threshold_writer with 16-sample blocks; a
// negedge monitor logs every bus strobe with its cycle number.
module tb_adaptive_threshold_writer;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] xk_d_fct;
   logic        dv_d_fct;
   logic [15:0] scale;
   logic [9:0]  window_size_cfg;
   logic        ws_load;
   logic        host_stb;
   logic [7:0]  host_addr;
   logic [31:0] host_data;
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic [31:0] th_current;
   logic [15:0] upd_cnt;

   int nchk = 0;
   int nfail = 0;
   int cyc = 0;
   int last_cyc;

   logic [7:0]  la[$];
   logic [31:0] ld[$];
   int          lc[$];

   adaptive_threshold_writer #(.TH_ADDR(1), .WS_ADDR(3), .LOG2_BLOCK(4)) dut (
      .clock           (clock),
      .reset           (reset),
      .enable          (enable),
      .xk_d_fct        (xk_d_fct),
      .dv_d_fct        (dv_d_fct),
      .scale           (scale),
      .window_size_cfg (window_size_cfg),
      .ws_load         (ws_load),
      .host_stb        (host_stb),
      .host_addr       (host_addr),
      .host_data       (host_data),
      .set_stb         (set_stb),
      .set_addr        (set_addr),
      .set_data        (set_data),
      .th_current      (th_current),
      .upd_cnt         (upd_cnt)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (set_stb) begin
         la.push_back(set_addr);
         ld.push_back(set_data);
         lc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clr_log();
      la.delete();
      ld.delete();
      lc.delete();
   endtask

   function automatic logic [7:0] a_at(input int i);
      return (i < la.size()) ? la[i] : 8'hxx;
   endfunction

   function automatic logic [31:0] d_at(input int i);
      return (i < ld.size()) ? ld[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic int c_at(input int i);
      return (i < lc.size()) ? lc[i] : -1;
   endfunction

   task automatic send(input int n, input logic [31:0] v);
      for (int i = 0; i < n; i++) begin
         xk_d_fct = v;
         dv_d_fct = 1'b1;
         last_cyc = cyc;
         tick();
      end
      dv_d_fct = 1'b0;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; xk_d_fct = '0; dv_d_fct = 1'b0;
      scale = '0; window_size_cfg = 10'd256; ws_load = 1'b0;
      host_stb = 1'b0; host_addr = '0; host_data = '0;
      repeat (3) tick();
      check("rst_stb", set_stb, 0);
      check("rst_addr", set_addr, 0);
      check("rst_data", set_data, 0);
      check("rst_th", th_current, 0);
      check("rst_upd", upd_cnt, 0);

      // window-size write after release, then silence while disabled
      reset = 1'b1;
      repeat (10) tick();
      check("ws_cnt", la.size(), 1);
      check("ws_addr", a_at(0), 3);
      check("ws_data", d_at(0), 32'h100);
      check("ws_hold_addr", set_addr, 3);

      // basic block: mean 100, x2
      clr_log();
      scale = 16'h0200; enable = 1'b1;
      tick();
      send(16, 32'd100);
      repeat (5) tick();
      check("b1_cnt", la.size(), 1);
      check("b1_addr", a_at(0), 1);
      check("b1_data", d_at(0), 200);
      check("b1_lat", c_at(0), last_cyc + 2);
      check("b1_th", th_current, 200);
      check("b1_upd", upd_cnt, 1);

      // saturation
      clr_log();
      scale = 16'h0400;
      send(16, 32'hFFFF_FFFF);
      repeat (5) tick();
      check("sat_cnt", la.size(), 1);
      check("sat_data", d_at(0), 32'hFFFF_FFFF);
      check("sat_upd", upd_cnt, 2);

      // host collides with the threshold slot
      clr_log();
      scale = 16'h0200;
      send(16, 32'd300);
      host_stb = 1'b1; host_addr = 8'd5; host_data = 32'hABCD;
      tick();
      host_stb = 1'b0;
      repeat (5) tick();
      check("hc_cnt", la.size(), 2);
      check("hc_a0", a_at(0), 5);
      check("hc_d0", d_at(0), 32'hABCD);
      check("hc_c0", c_at(0), last_cyc + 2);
      check("hc_a1", a_at(1), 1);
      check("hc_d1", d_at(1), 600);
      check("hc_c1", c_at(1), last_cyc + 3);
      check("hc_upd", upd_cnt, 3);

      // partial block discarded on disable
      clr_log();
      scale = 16'h0100;
      send(10, 32'd50);
      enable = 1'b0;
      repeat (3) tick();
      check("pb_none", la.size(), 0);
      enable = 1'b1;
      tick();
      send(16, 32'd50);
      repeat (5) tick();
      check("pb_cnt", la.size(), 1);
      check("pb_data", d_at(0), 50);
      check("pb_th", th_current, 50);
      check("pb_upd", upd_cnt, 4);

      // ws_load re-write
      enable = 1'b0;
      repeat (3) tick();
      clr_log();
      window_size_cfg = 10'h155;
      ws_load = 1'b1;
      last_cyc = cyc;
      tick();
      ws_load = 1'b0;
      repeat (5) tick();
      check("wl_cnt", la.size(), 1);
      check("wl_addr", a_at(0), 3);
      check("wl_data", d_at(0), 32'h155);
      check("wl_lat", c_at(0), last_cyc + 2);

      // reset mid-block
      clr_log();
      enable = 1'b1;
      tick();
      send(8, 32'd100);
      reset = 1'b0;
      #1;
      check("mr_stb", set_stb, 0);
      tick();
      check("mr_th", th_current, 0);
      check("mr_upd", upd_cnt, 0);
      enable = 1'b0;
      reset = 1'b1;
      repeat (8) tick();
      check("mr_cnt", la.size(), 1);
      check("mr_addr", a_at(0), 3);
      check("mr_data", d_at(0), 32'h155);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
